// File: rtl/config_loader.sv
// config_loader: streams host words LSB-first into a CONF_WIDTH-bit tile configuration chain, then pulses cset to commit.
// Ports: clk, rst (async, active-high); start/abort control; word_data/word_valid/word_ready host handshake;
//        shift_out/cen serial chain drive; cset commit pulse; busy (FETCH/SHIFT/COMMIT); done (DONE).
module config_loader #(
  parameter int CONF_WIDTH = 3983,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              shift_out,
  output logic              cen,
  output logic              cset,
  output logic              busy,
  output logic              done
);
  localparam int BW = $clog2(CONF_WIDTH + 1);
  localparam int CW = $clog2(WORD_W + 1);
  typedef enum logic [2:0] {IDLE, FETCH, SHIFT, COMMIT, DONE} state_t;
  state_t state, state_n;
  logic [BW-1:0] sent, sent_n, rem;
  logic [CW-1:0] cnt, cnt_n;
  logic [WORD_W-1:0] sreg, sreg_n;
  assign rem = BW'(CONF_WIDTH) - sent;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sent  <= '0;
      cnt   <= '0;
      sreg  <= '0;
    end else begin
      state <= state_n;
      sent  <= sent_n;
      cnt   <= cnt_n;
      sreg  <= sreg_n;
    end
  end
  // The final word only carries the bits still owed to the chain; its upper bits are never shifted.
  always_comb begin
    state_n = state;
    sent_n  = sent;
    cnt_n   = cnt;
    sreg_n  = sreg;
    case (state)
      IDLE, DONE: if (start) begin
        state_n = FETCH;
        sent_n  = '0;
      end
      FETCH: if (abort) state_n = IDLE;
      else if (word_valid) begin
        state_n = SHIFT;
        sreg_n  = word_data;
        cnt_n   = (32'(rem) > WORD_W) ? CW'(WORD_W) : CW'(rem);
      end
      SHIFT: if (abort) state_n = IDLE;
      else begin
        sreg_n = sreg >> 1;
        sent_n = sent + 1'b1;
        cnt_n  = cnt - 1'b1;
        if (cnt == CW'(1)) state_n = (sent_n == BW'(CONF_WIDTH)) ? COMMIT : FETCH;
      end
      COMMIT: state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  assign word_ready = state == FETCH;
  assign cen        = state == SHIFT;
  assign shift_out  = cen & sreg[0];
  assign cset       = state == COMMIT;
  assign busy       = (state == FETCH) | (state == SHIFT) | (state == COMMIT);
  assign done       = state == DONE;
endmodule
